// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : Memory-mapped interrupt controller. Latches, masks and
//                prioritises up to 32 interrupt lines and runs a non-nested
//                request / acknowledge / end-of-interrupt cycle to the CPU.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_ctrl #(
    parameter int WIDTH = 32,
    parameter int NIRQ  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic [NIRQ-1:0]  irq_in,
    input  logic             irq_ack,
    output logic             irq_req,
    output logic [4:0]       irq_num,
    output logic             irq_active
);

    // Register offsets
    localparam logic [2:0] c_addr_pend    = 3'd0;
    localparam logic [2:0] c_addr_enable  = 3'd1;
    localparam logic [2:0] c_addr_edge    = 3'd2;
    localparam logic [2:0] c_addr_cur     = 3'd3;
    localparam logic [2:0] c_addr_setpend = 3'd4;
    localparam logic [2:0] c_addr_ctrl    = 3'd5;

    // FSM encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_serv = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [NIRQ-1:0] r_pend;
    logic [NIRQ-1:0] r_enable;
    logic [NIRQ-1:0] r_edge;
    logic [NIRQ-1:0] r_prev_in;
    logic            r_gie;
    logic [4:0]      r_irq_num;

    logic            w_wr;
    logic [NIRQ-1:0] w_din;
    logic [NIRQ-1:0] w_hw_set;
    logic [NIRQ-1:0] w_sw_set;
    logic [NIRQ-1:0] w_w1c;
    logic [NIRQ-1:0] w_ack_clr;
    logic [NIRQ-1:0] w_cand;
    logic [31:0]     w_cand32;
    logic [4:0]      w_winner;
    logic            w_any;
    logic            w_latched_ok;
    logic            w_ack;
    logic            w_eoi;
    logic            w_unused_din;

    assign w_wr         = cs & wen;
    assign w_din        = din[NIRQ-1:0];
    assign w_unused_din = ^din;

    // Edge lines fire on a rising transition, level lines whenever high
    assign w_hw_set = irq_in & (~r_edge | ~r_prev_in);
    assign w_sw_set = (w_wr && addr == c_addr_setpend) ? w_din : '0;
    assign w_w1c    = (w_wr && addr == c_addr_pend)    ? w_din : '0;

    // Ack is only meaningful while requesting; EOI only while in service
    assign w_ack = (r_state == c_st_req) & irq_ack;
    assign w_eoi = (r_state == c_st_serv) & w_wr & (addr == c_addr_cur);

    assign w_cand = r_pend & r_enable & {NIRQ{r_gie}};
    assign w_any  = |w_cand;

    // Zero-extended candidate set so the 5-bit interrupt number can index it
    always_comb begin
        w_cand32            = '0;
        w_cand32[NIRQ-1:0]  = w_cand;
    end

    assign w_latched_ok = w_cand32[r_irq_num];

    // Lowest set index wins
    always_comb begin
        w_winner = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (w_cand[i]) w_winner = i[4:0];
        end
    end

    // Acknowledge retires the serviced source; a still-high level line re-sets it
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NIRQ; i++) begin
            w_ack_clr[i] = w_ack && (r_irq_num == i[4:0]);
        end
    end

    // Configuration, pending capture and interrupt number latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend    <= '0;
            r_enable  <= '0;
            r_edge    <= '0;
            r_prev_in <= '0;
            r_gie     <= 1'b0;
            r_irq_num <= '0;
        end else begin
            r_prev_in <= irq_in;
            // Sets are applied after clears so a set always beats a clear
            r_pend    <= (r_pend & ~(w_w1c | w_ack_clr)) | w_hw_set | w_sw_set;
            if (w_wr && addr == c_addr_enable) r_enable <= w_din;
            if (w_wr && addr == c_addr_edge)   r_edge   <= w_din;
            if (w_wr && addr == c_addr_ctrl)   r_gie    <= din[0];
            if (r_state == c_st_idle && w_any) r_irq_num <= w_winner;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_next;
    end

    // FSM next-state logic; a pending higher-priority source never preempts
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_any) w_state_next = c_st_req;
            c_st_req: begin
                if (w_ack)              w_state_next = c_st_serv;
                else if (!w_latched_ok) w_state_next = c_st_idle;
            end
            c_st_serv: if (w_eoi) w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // FSM outputs
    always_comb begin
        irq_req    = (r_state == c_st_req);
        irq_active = (r_state == c_st_serv);
        irq_num    = r_irq_num;
    end

    // Read mux, combinational from registered state
    always_comb begin
        dout = '0;
        if (cs) begin
            case (addr)
                c_addr_pend:   dout[NIRQ-1:0] = r_pend;
                c_addr_enable: dout[NIRQ-1:0] = r_enable;
                c_addr_edge:   dout[NIRQ-1:0] = r_edge;
                c_addr_cur: begin
                    dout[WIDTH-1] = irq_active;
                    dout[4:0]     = r_irq_num;
                end
                c_addr_ctrl:   dout[0] = r_gie;
                default:       dout = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_ctrl
//  Description : Self-checking bench for irq_ctrl: directed scenarios then
//                randomized traffic, compared against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_ctrl;

    localparam int WIDTH = 32;
    localparam int NIRQ  = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cs;
    logic             wen;
    logic [2:0]       addr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [NIRQ-1:0]  irq_in;
    logic             irq_ack;
    logic             irq_req;
    logic [4:0]       irq_num;
    logic             irq_active;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state: phase 0 = idle, 1 = requesting, 2 = in handler
    logic [NIRQ-1:0] m_pend, m_en, m_edge, m_prev;
    logic            m_gie;
    int              m_phase;
    logic [4:0]      m_num;

    irq_ctrl #(.WIDTH(WIDTH), .NIRQ(NIRQ)) dut (
        .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr),
        .din(din), .dout(dout), .irq_in(irq_in), .irq_ack(irq_ack),
        .irq_req(irq_req), .irq_num(irq_num), .irq_active(irq_active)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (cs) begin
            case (a)
                3'd0: r = {24'h0, m_pend};
                3'd1: r = {24'h0, m_en};
                3'd2: r = {24'h0, m_edge};
                3'd3: r = {(m_phase == 2), 26'h0, m_num};
                3'd5: r = {31'h0, m_gie};
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    // Advance one clock: derive the model's next state from the rules, then compare outputs
    task automatic tick();
        logic [NIRQ-1:0] np, ne, ned, cand;
        logic            ng, found, set_b, clr_b;
        int              nph;
        logic [4:0]      nn;
        bit              wr;
        wr = cs && wen;
        if (reset) begin
            np = '0; ne = '0; ned = '0; ng = 1'b0; nph = 0; nn = '0;
        end else begin
            cand = m_gie ? (m_pend & m_en) : '0;
            np = m_pend;
            for (int i = 0; i < NIRQ; i++) begin
                set_b = (m_edge[i] ? (irq_in[i] && !m_prev[i]) : irq_in[i])
                        || (wr && addr == 3'd4 && din[i]);
                clr_b = (wr && addr == 3'd0 && din[i])
                        || (m_phase == 1 && irq_ack && m_num == i);
                if (set_b)      np[i] = 1'b1;
                else if (clr_b) np[i] = 1'b0;
            end
            ne  = (wr && addr == 3'd1) ? din[NIRQ-1:0] : m_en;
            ned = (wr && addr == 3'd2) ? din[NIRQ-1:0] : m_edge;
            ng  = (wr && addr == 3'd5) ? din[0] : m_gie;
            nph = m_phase;
            nn  = m_num;
            if (m_phase == 0) begin
                found = 1'b0;
                for (int i = 0; i < NIRQ; i++) begin
                    if (cand[i] && !found) begin
                        found = 1'b1;
                        nn    = 5'(i);
                        nph   = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (irq_ack) nph = 2;
                else if (((cand >> m_num) & 8'h01) == 8'h00) nph = 0;
            end else if (m_phase == 2 && wr && addr == 3'd3) begin
                nph = 0;
            end
        end
        @(posedge clk);
        #1;
        m_pend = np; m_en = ne; m_edge = ned; m_gie = ng;
        m_phase = nph; m_num = nn;
        m_prev = reset ? '0 : irq_in;
        chk("irq_req", {31'h0, irq_req}, {31'h0, m_phase == 1});
        chk("irq_active", {31'h0, irq_active}, {31'h0, m_phase == 2});
        chk("irq_num", {27'h0, irq_num}, {27'h0, m_num});
    endtask

    task automatic check_rd(input logic [2:0] a, input string tag);
        cs = 1'b1; wen = 1'b0; addr = a;
        #1;
        chk(tag, dout, model_rd(a));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wen = 1'b1; addr = a; din = d;
        tick();
        cs = 1'b0; wen = 1'b0; din = '0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; wen = 1'b0; addr = '0; din = '0;
        irq_in = '0; irq_ack = 1'b0;

        // Reset to idle
        tick();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) check_rd(3'(a), "reset_read");
        cs = 1'b0;
        #1;
        chk("dout_cs0", dout, 32'h0);

        // Edge request cycle on line 0
        wr(3'd1, 32'h01); wr(3'd2, 32'h01); wr(3'd5, 32'h01);
        irq_in = 8'h01; tick();
        irq_in = 8'h00; tick();
        chk("edge_req", {31'h0, irq_req}, 32'h1);
        check_rd(3'd0, "edge_pend");
        chk("edge_pend_const", dout, 32'h1);
        ack();
        check_rd(3'd3, "edge_cur");
        chk("edge_cur_const", dout, 32'h8000_0000);
        check_rd(3'd0, "edge_pend_clr");
        wr(3'd3, 32'h0);
        chk("edge_eoi_active", {31'h0, irq_active}, 32'h0);
        tick();
        chk("edge_eoi_req", {31'h0, irq_req}, 32'h0);

        // Priority and no preemption
        wr(3'd2, 32'hFF); wr(3'd1, 32'h26); wr(3'd4, 32'h24);
        tick();
        chk("prio_first", {27'h0, irq_num}, 32'd2);
        irq_in = 8'h02; tick();
        irq_in = 8'h00; tick();
        chk("no_preempt", {27'h0, irq_num}, 32'd2);
        ack(); wr(3'd3, 32'h0); tick();
        chk("prio_second", {27'h0, irq_num}, 32'd1);
        ack(); wr(3'd3, 32'h0); tick();
        chk("prio_third", {27'h0, irq_num}, 32'd5);
        ack(); wr(3'd3, 32'h0);

        // Level retrigger on line 3
        wr(3'd2, 32'hF7); wr(3'd1, 32'h08);
        irq_in = 8'h08; tick(); tick();
        ack(); wr(3'd3, 32'h0); tick();
        chk("level_rereq", {31'h0, irq_req}, 32'h1);
        chk("level_num", {27'h0, irq_num}, 32'd3);
        wr(3'd0, 32'h08);
        check_rd(3'd0, "level_w1c");
        chk("level_w1c_const", dout & 32'h08, 32'h08);
        irq_in = 8'h00;
        ack(); wr(3'd3, 32'h0); tick();
        chk("level_done", {31'h0, irq_req}, 32'h0);

        // Withdraw and global gating
        wr(3'd2, 32'hFF); wr(3'd1, 32'h01); wr(3'd4, 32'h01);
        tick();
        chk("wd_req", {31'h0, irq_req}, 32'h1);
        wr(3'd1, 32'h00); tick();
        chk("wd_drop", {31'h0, irq_req}, 32'h0);
        wr(3'd0, 32'h01); wr(3'd5, 32'h0); wr(3'd1, 32'hFF); wr(3'd4, 32'h10);
        tick();
        check_rd(3'd0, "gie_pend");
        chk("gie_pend_const", dout, 32'h10);
        chk("gie_off_req", {31'h0, irq_req}, 32'h0);
        wr(3'd5, 32'h1); tick();
        chk("gie_on_req", {31'h0, irq_req}, 32'h1);
        chk("gie_on_num", {27'h0, irq_num}, 32'd4);

        // Set/clear collision, then reset while in service
        ack(); wr(3'd3, 32'h0); wr(3'd1, 32'h0);
        irq_in = 8'h01; wr(3'd0, 32'h01);
        irq_in = 8'h00;
        check_rd(3'd0, "collide");
        chk("collide_const", dout, 32'h1);
        wr(3'd1, 32'h01); tick(); ack();
        chk("serv_before_reset", {31'h0, irq_active}, 32'h1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_req", {31'h0, irq_req}, 32'h0);
        chk("rst_active", {31'h0, irq_active}, 32'h0);
        for (int a = 0; a < 8; a++) check_rd(3'(a), "rst_read");

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            irq_in = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 9) < 3) begin
                cs = 1'b1; wen = 1'b1;
                addr = 3'($urandom_range(0, 7));
                din = $urandom;
            end else begin
                cs = 1'($urandom_range(0, 1)); wen = 1'b0;
            end
            irq_ack = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            tick();
            reset = 1'b0; irq_ack = 1'b0; wen = 1'b0; din = '0;
            check_rd(3'($urandom_range(0, 7)), "rand_read");
            cs = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
